// File: rtl/wb_stage.sv
// wb_stage: registered writeback stage for the RISC-V core.
// Picks the writeback value from the ALU result, PC+PC_INC, or aligned load
// data (memory or IO). Loads wait MEM_LAT cycles before the read word is
// sampled. Results are presented as a one-cycle out_valid pulse; out_data and
// out_rd hold their values until the next pulse.
//
// Handshake: an instruction is accepted on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE, and it does not depend
// on in_valid. Upstream must hold every in_* field stable while in_valid is
// high and in_ready is low. There is no backpressure on the output side.
// The FSM state is visible on busy (high in WAIT).
module wb_stage #(
  parameter int XLEN    = 32,
  parameter int PC_INC  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_we,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic            in_io,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] io_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_misalign,
  output logic            busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_accept;
  logic            w_is_load;
  logic            w_load_done;

  // Load fields captured at acceptance
  logic [4:0]      r_rd;
  logic            r_reg_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic            r_io;

  logic [XLEN-1:0] w_nl_data;
  logic [XLEN-1:0] w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_mis;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_data;
  logic [4:0]      r_out_rd;
  logic            r_out_we;
  logic            r_out_misalign;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_WAIT);
  assign w_accept  = in_valid && in_ready;
  assign w_is_load = (in_wb_sel == 2'd1);

  // Non-load result; wb_sel=3 is reserved and falls back to the ALU value
  assign w_nl_data = (in_wb_sel == 2'd2) ? (in_pc + XLEN'(PC_INC)) : in_alu;

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a load parks in WAIT until the counter reaches zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_load) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_load_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the load descriptor so upstream is free after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd      <= 5'd0;
      r_reg_we  <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
      r_io      <= 1'b0;
    end else if (w_accept && w_is_load) begin
      r_rd      <= in_rd;
      r_reg_we  <= in_reg_we;
      r_funct3  <= in_funct3;
      r_addr_lo <= in_addr_lo;
      r_io      <= in_io;
    end
  end

  assign w_word = r_io ? io_rdata : mem_rdata;
  assign w_half = r_addr_lo[1] ? w_word[31:16] : w_word[15:0];

  // Byte lane selected by the low address bits
  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr_lo)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  // Extend the selected lane; misaligned or unknown funct3 yields zero data
  always_comb begin
    w_ld_data = '0;
    w_ld_mis  = 1'b0;
    case (r_funct3)
      3'b000: w_ld_data = XLEN'($signed(w_byte));
      3'b100: w_ld_data = XLEN'(w_byte);
      3'b001: begin
        if (r_addr_lo[0]) w_ld_mis  = 1'b1;
        else              w_ld_data = XLEN'($signed(w_half));
      end
      3'b101: begin
        if (r_addr_lo[0]) w_ld_mis  = 1'b1;
        else              w_ld_data = XLEN'(w_half);
      end
      3'b010: begin
        if (r_addr_lo != 2'd0) w_ld_mis  = 1'b1;
        else                   w_ld_data = XLEN'($signed(w_word[31:0]));
      end
      default: w_ld_mis = 1'b1;
    endcase
  end

  // Output registers: pulse flags clear every cycle, data and rd hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_rd       <= 5'd0;
      r_out_we       <= 1'b0;
      r_out_misalign <= 1'b0;
    end else begin
      r_out_valid    <= 1'b0;
      r_out_we       <= 1'b0;
      r_out_misalign <= 1'b0;
      if (w_accept && !w_is_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_nl_data;
        r_out_rd    <= in_rd;
        r_out_we    <= in_reg_we && (in_rd != 5'd0);
      end else if (w_load_done) begin
        r_out_valid    <= 1'b1;
        r_out_data     <= w_ld_data;
        r_out_rd       <= r_rd;
        r_out_we       <= r_reg_we && (r_rd != 5'd0) && !w_ld_mis;
        r_out_misalign <= w_ld_mis;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_rd       = r_out_rd;
  assign out_we       = r_out_we;
  assign out_misalign = r_out_misalign;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage (XLEN=32, PC_INC=4, MEM_LAT=2).
// A transaction-level model predicts the outputs every cycle; directed tests
// also pin literal values and latencies.
module tb_wb_stage;

  localparam int XLEN = 32;
  localparam int PCI  = 4;
  localparam int ML   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_wb_sel = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_alu = '0;
  logic [4:0]      in_rd = '0;
  logic            in_reg_we = 1'b0;
  logic [2:0]      in_funct3 = '0;
  logic [1:0]      in_addr_lo = '0;
  logic            in_io = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic [XLEN-1:0] io_rdata = '0;
  logic            out_valid;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_misalign;
  logic            busy;

  wb_stage #(.XLEN(XLEN), .PC_INC(PCI), .MEM_LAT(ML)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_pc(in_pc), .in_alu(in_alu),
    .in_rd(in_rd), .in_reg_we(in_reg_we), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_io(in_io),
    .mem_rdata(mem_rdata), .io_rdata(io_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_we(out_we), .out_misalign(out_misalign), .busy(busy)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Load result from the architectural rules, using plain arithmetic.
  function automatic void ld_model(input logic [31:0] w, input logic [2:0] f3,
                                   input logic [1:0] alo,
                                   output logic [31:0] d, output bit bad);
    logic [31:0] b;
    logic [31:0] h;
    b   = (w >> (alo * 8)) & 32'hFF;
    h   = (w >> (alo[1] * 16)) & 32'hFFFF;
    bad = 1'b0;
    d   = 32'd0;
    case (f3)
      3'b000: d = (b >= 128) ? b - 256 : b;
      3'b100: d = b;
      3'b001: if (alo[0]) bad = 1'b1; else d = (h >= 32768) ? h - 65536 : h;
      3'b101: if (alo[0]) bad = 1'b1; else d = h;
      3'b010: if (alo != 2'd0) bad = 1'b1; else d = w;
      default: bad = 1'b1;
    endcase
    if (bad) d = 32'd0;
  endfunction

  bit          m_pend;
  int          m_edge;
  int          m_due;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [2:0]  m_f3;
  logic [1:0]  m_alo;
  logic        m_io;
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [4:0]  exp_rd;
  logic        exp_we;
  logic        exp_mis;

  // Model: at most one load outstanding, completing ML edges after acceptance
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] d;
    bit bad;
    if (!rst_n) begin
      m_pend = 0; m_edge = 0; m_due = 0;
      exp_valid = 0; exp_data = 0; exp_rd = 0; exp_we = 0; exp_mis = 0;
    end else begin
      m_edge++;
      exp_valid = 0; exp_we = 0; exp_mis = 0;
      if (m_pend) begin
        if (m_edge == m_due) begin
          ld_model(m_io ? io_rdata : mem_rdata, m_f3, m_alo, d, bad);
          exp_valid = 1; exp_data = d; exp_rd = m_rd;
          exp_we = m_we && (m_rd != 0) && !bad; exp_mis = bad;
          m_pend = 0;
        end
      end else if (in_valid) begin
        if (in_wb_sel == 2'd1) begin
          m_pend = 1; m_due = m_edge + ML;
          m_rd = in_rd; m_we = in_reg_we; m_f3 = in_funct3; m_alo = in_addr_lo; m_io = in_io;
        end else begin
          exp_valid = 1;
          exp_data  = (in_wb_sel == 2'd2) ? in_pc + PCI : in_alu;
          exp_rd    = in_rd;
          exp_we    = in_reg_we && (in_rd != 0);
        end
      end
    end
  end

  // Compare process: every cycle, just after the active edge
  always @(posedge clk) begin
    #1;
    chk("cmp_out_valid", out_valid, exp_valid);
    chk("cmp_out_data", out_data, exp_data);
    chk("cmp_out_rd", out_rd, exp_rd);
    chk("cmp_out_we", out_we, exp_we);
    chk("cmp_out_misalign", out_misalign, exp_mis);
    chk("cmp_in_ready", in_ready, !m_pend);
    chk("cmp_busy", busy, m_pend);
  end

  // ---------------- driver tasks ----------------
  // Present one instruction and return on the edge that accepts it
  task automatic issue(input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] rd, input logic we, input logic [2:0] f3,
                       input logic [1:0] alo, input logic io);
    int k;
    @(negedge clk);
    in_wb_sel = sel; in_pc = pc; in_alu = alu; in_rd = rd; in_reg_we = we;
    in_funct3 = f3; in_addr_lo = alo; in_io = io; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("issue_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
  endtask

  // Called on the accepting edge; returns cycle index of out_valid (accept = 0)
  task automatic wait_out(output int cyc, output bit ready_low);
    cyc = 1;
    ready_low = 1'b1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [4:0] rd, input logic io, input logic [31:0] e_data,
                         input logic e_mis, input logic e_we);
    int  c;
    bit  rl;
    issue(2'd1, 32'h0, 32'h0, rd, 1'b1, f3, alo, io);
    wait_out(c, rl);
    chk({nm, "_latency"}, c, ML + 1);
    chk({nm, "_ready_low_in_wait"}, rl, 1'b1);
    chk({nm, "_ready_at_valid"}, in_ready, 1'b1);
    chk({nm, "_data"}, out_data, e_data);
    chk({nm, "_misalign"}, out_misalign, e_mis);
    chk({nm, "_we"}, out_we, e_we);
    chk({nm, "_rd"}, out_rd, rd);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  c;
    bit  rl;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_we", out_we, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU back-to-back, rd=5
    issue(2'd0, 32'h0, 32'h1234, 5'd5, 1'b1, 3'd0, 2'd0, 1'b0);
    #1;
    chk("alu1_valid", out_valid, 1'b1);
    chk("alu1_data", out_data, 32'h1234);
    chk("alu1_we", out_we, 1'b1);
    issue(2'd0, 32'h0, 32'hDEAD, 5'd5, 1'b1, 3'd0, 2'd0, 1'b0);
    #1;
    in_valid = 1'b0;
    chk("alu2_valid", out_valid, 1'b1);
    chk("alu2_data", out_data, 32'hDEAD);
    chk("alu2_rd", out_rd, 5'd5);
    @(posedge clk); #1;
    chk("alu2_pulse_single", out_valid, 1'b0);
    chk("alu2_we_drop", out_we, 1'b0);

    // Link value wraps
    issue(2'd2, 32'hFFFF_FFFC, 32'h5555, 5'd1, 1'b1, 3'd0, 2'd0, 1'b0);
    wait_out(c, rl);
    chk("link_latency", c, 1);
    chk("link_data", out_data, 32'h0);
    chk("link_we", out_we, 1'b1);

    // Reserved wb_sel behaves as ALU
    issue(2'd3, 32'h100, 32'hCAFE_F00D, 5'd9, 1'b1, 3'd0, 2'd0, 1'b0);
    wait_out(c, rl);
    chk("sel3_data", out_data, 32'hCAFE_F00D);

    // Loads
    mem_rdata = 32'h80F1_7F82;
    io_rdata  = 32'h0000_0000;
    do_load("lb0",  3'b000, 2'd0, 5'd3, 1'b0, 32'hFFFF_FF82, 1'b0, 1'b1);
    do_load("lbu1", 3'b100, 2'd1, 5'd3, 1'b0, 32'h0000_007F, 1'b0, 1'b1);
    do_load("lh2",  3'b001, 2'd2, 5'd4, 1'b0, 32'hFFFF_80F1, 1'b0, 1'b1);
    do_load("lhu0", 3'b101, 2'd0, 5'd4, 1'b0, 32'h0000_7F82, 1'b0, 1'b1);
    do_load("lb3",  3'b000, 2'd3, 5'd4, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1);
    do_load("lw0",  3'b010, 2'd0, 5'd6, 1'b0, 32'h80F1_7F82, 1'b0, 1'b1);

    // Misaligned / illegal
    do_load("lw_mis",  3'b010, 2'd1, 5'd7, 1'b0, 32'h0, 1'b1, 1'b0);
    do_load("lh_mis",  3'b001, 2'd3, 5'd7, 1'b0, 32'h0, 1'b1, 1'b0);
    do_load("f3_011",  3'b011, 2'd0, 5'd7, 1'b0, 32'h0, 1'b1, 1'b0);

    // IO region, then rd=0
    mem_rdata = 32'h1234_5678;
    io_rdata  = 32'h0000_00A5;
    do_load("io_lbu",    3'b100, 2'd0, 5'd8, 1'b1, 32'h0000_00A5, 1'b0, 1'b1);
    do_load("io_lbu_x0", 3'b100, 2'd0, 5'd0, 1'b1, 32'h0000_00A5, 1'b0, 1'b0);

    // Reset in the middle of a load
    issue(2'd1, 32'h0, 32'h0, 5'd10, 1'b1, 3'b010, 2'd0, 1'b0);
    #1;
    in_valid = 1'b0;
    chk("midwait_busy", busy, 1'b1);
    chk("midwait_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", in_ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_data", out_data, 32'h0);
    chk("async_rst_rd", out_rd, 5'd0);
    chk("async_rst_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("dropped_load_no_valid", out_valid, 1'b0);
      chk("post_rst_ready", in_ready, 1'b1);
    end

    // Alive after reset
    issue(2'd0, 32'h0, 32'h0000_0042, 5'd2, 1'b1, 3'd0, 2'd0, 1'b0);
    wait_out(c, rl);
    chk("post_rst_alu", out_data, 32'h42);

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    n_checks++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
